// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin front end for a single-port scratch memory with
// one-cycle registered read; issues one command per cycle and steers read data back.
module mem_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_wr_rdn,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_data,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_wr_rdn,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_data,

    output logic              mem_wr_rdn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    logic              last_reg;
    logic [1:0]        req_valid;
    logic [1:0]        req_grant;
    logic [1:0]        rsp_hit;
    logic              accept;
    logic              winner;

    logic              mem_wr_rdn_reg, mem_wr_rdn_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;

    logic              s1_valid_reg;
    logic              s1_tag_reg;
    logic              s1_rd_reg;
    logic              s2_valid_reg;
    logic              s2_tag_reg;

    assign req_valid = {b_valid, a_valid};

    // A requester wins if it is alone, or if the other one was served last.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req_grant[gi] = req_valid[gi] && !rst &&
                               (!req_valid[1-gi] || (last_reg != 1'(gi)));
        assign rsp_hit[gi]   = s2_valid_reg && (s2_tag_reg == 1'(gi));
    end

    assign accept  = |req_grant;
    assign winner  = req_grant[1] ? REQ_B : REQ_A;
    assign a_ready = req_grant[0];
    assign b_ready = req_grant[1];

    // Idle cycles present a read so the memory contents can never be disturbed.
    always_comb begin
        mem_wr_rdn_next = 1'b0;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        if (accept) begin
            mem_wr_rdn_next = (winner == REQ_B) ? b_wr_rdn : a_wr_rdn;
            mem_addr_next   = (winner == REQ_B) ? b_addr   : a_addr;
            mem_wdata_next  = (winner == REQ_B) ? b_wdata  : a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg       <= REQ_B;
            mem_wr_rdn_reg <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            s1_valid_reg   <= 1'b0;
            s1_tag_reg     <= REQ_A;
            s1_rd_reg      <= 1'b0;
            s2_valid_reg   <= 1'b0;
            s2_tag_reg     <= REQ_A;
        end else begin
            mem_wr_rdn_reg <= mem_wr_rdn_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            s1_valid_reg   <= accept;
            s1_tag_reg     <= winner;
            s1_rd_reg      <= !mem_wr_rdn_next;
            if (accept) begin
                last_reg <= winner;
            end
            s2_valid_reg   <= s1_valid_reg && s1_rd_reg;
            s2_tag_reg     <= s1_tag_reg;
        end
    end

    assign mem_wr_rdn  = mem_wr_rdn_reg;
    assign mem_addr    = mem_addr_reg;
    assign mem_wdata   = mem_wdata_reg;

    assign a_rsp_valid = rsp_hit[0];
    assign b_rsp_valid = rsp_hit[1];
    assign a_rsp_data  = mem_rdata;
    assign b_rsp_data  = mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single-port 16x8 scratch memory (`wr_rdn`, `addr`, `in_data`, `out_data`; one-cycle registered read) between two requesters, A and B. Each requester has a valid/ready request channel and a read-response strobe. The arbiter registers the winning command onto the memory port and routes the returned read data back to the requester that issued it. It sits between the two bus-side masters and the memory instance and is the only driver of the memory port.

## Interface
- `ADDR_W`, default 4: memory address width.
- `DATA_W`, default 8: memory data width.

- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_valid`  in  1  requester A command valid.
- `a_ready`  out  1  A command accepted this cycle.
- `a_wr_rdn`  in  1  1 = write, 0 = read.
- `a_addr`  in  ADDR_W  A address.
- `a_wdata`  in  DATA_W  A write data.
- `a_rsp_valid`  out  1  A read data valid (one-cycle pulse).
- `a_rsp_data`  out  DATA_W  A read data.
- `b_*`: identical set for requester B.
- `mem_wr_rdn`  out  1  to memory `wr_rdn`.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_wdata`  out  DATA_W  to memory `in_data`.
- `mem_rdata`  in  DATA_W  from memory `out_data`.

## Operation
- **Handshake:** a command transfers when `x_valid && x_ready`. Requesters hold `x_valid` and the command fields stable until accepted.
- **Arbitration:** combinational, from the current valids and the registered priority pointer `last`.
  - Only one valid: that requester is granted.
  - Both valid: the requester not in `last` wins.
  - At most one `x_ready` is high per cycle. `x_ready` is low whenever `x_valid` is low.
  - `last` updates to the granted requester on each accept. It holds when nothing is accepted.
- **Issue stage (registered):**
  - On accept, `mem_wr_rdn`, `mem_addr` and `mem_wdata` load the winner's fields. Stage-1 valid is set, and a stage-1 tag holds the winner (A/B) and whether the command is a read.
  - With no accept, `mem_wr_rdn` loads 0 (an idle read). `mem_addr` and `mem_wdata` hold their values. Stage-1 valid clears. The memory is therefore never written while idle.
- **Response stage (registered):** stage-2 valid and tag load from stage-1 when the stage-1 command is a read.
  - `a_rsp_valid = s2_valid && s2_tag==A`; `b_rsp_valid` likewise for B.
  - `a_rsp_data` and `b_rsp_data` both equal `mem_rdata` combinationally. They are valid only while the matching `rsp_valid` is high.
- Writes produce no response.
- One command per cycle in total. Back-to-back accepts are allowed, from the same or alternating requesters.
- Commands complete in accept order. A write accepted in cycle N followed by a read of the same address accepted in N+1 returns the new data.

## Timing
- **Reset (`rst` high at a clock edge):**
  - `mem_wr_rdn`=0, `mem_addr`=0, `mem_wdata`=0.
  - Stage-1 and stage-2 valids cleared, so `a_rsp_valid`=`b_rsp_valid`=0.
  - `last`=B, so A wins the first tie.
  - `a_ready`=`b_ready`=0 while `rst` is high.
- **Reset mid-operation:** in-flight reads are discarded and no response pulse appears after reset. The requester re-issues.
- **Latency:**
  - Command accepted in cycle N is driven on the memory port in N+1.
  - The memory samples it at the end of N+1.
  - For a read, `x_rsp_valid` is high in cycle N+2 with `mem_rdata`.
- **Throughput:** one read response per cycle is sustainable. No backpressure on responses; requesters must accept `rsp` when pulsed.
- **Simultaneous request and response:** a requester may have a new command accepted in the same cycle its earlier read responds.
- **Fairness:** with both valid continuously, grants strictly alternate A, B, A, B.
- **Address wrap:** none. Addresses are passed through unmodified, and all 2^ADDR_W values are legal.

## Test plan
- **Reset:** hold `rst` 2 cycles with `a_valid`=1 -> `a_ready`=0 and all outputs 0. First cycle after release, `a_ready`=1.
- **Single write then read:** A writes addr 3 = 0x5A, then A reads addr 3 -> `a_rsp_valid` exactly 2 cycles after the read accept, `a_rsp_data`=0x5A, `b_rsp_valid` stays 0.
- **Contention:** A and B both valid for 6 cycles, reading addrs 1 and 2, preloaded 0x11 and 0x22 -> grants A,B,A,B,A,B. Responses alternate 0x11/0x22 to A/B, each 2 cycles after its grant.
- **Write/read hazard:** B writes addr 7 = 0xC3 in cycle N, A reads addr 7 in N+1 -> A receives 0xC3 in N+3.
- **Reset mid-flight:** A read accepted in cycle N, `rst` asserted in N+1 -> no `a_rsp_valid` in N+2 or later.
- **Idle safety:** write 0xFF to addr 0, then 10 idle cycles, then read addr 0 -> 0xFF. `mem_wr_rdn` stays 0 throughout the idle cycles.
